// File: rtl/strobe_enc_pkg.sv
// Shared widths and reset constants for the 16-line strobe encoder.
package strobe_enc_pkg;

    localparam int unsigned STROBE_W = 16;
    localparam int unsigned CODE_W   = 4;

    // Strobes are active-low, so the idle synchronizer value is all ones.
    localparam logic [STROBE_W-1:0] SYNC_RESET = '1;

endpackage

// File: rtl/priority_enc_16.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit plus an any flag.
module priority_enc_16
    import strobe_enc_pkg::*;
(
    input  logic [STROBE_W-1:0] vec,
    output logic [CODE_W-1:0]   idx,
    output logic                any
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = STROBE_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/strobe_encoder_16.sv
// Captures falling edges on 16 active-low strobes as pending events and presents them
// one at a time, lowest index first, as a 4-bit code over a valid/ready handshake.
module strobe_encoder_16
    import strobe_enc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [STROBE_W-1:0] y_n,
    output logic [CODE_W-1:0]   code,
    output logic                valid,
    input  logic                ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam int unsigned SyncW  = (SYNC_STAGES == 0) ? STROBE_W : SYNC_STAGES * STROBE_W;
    localparam int unsigned ArmCnt = SYNC_STAGES + 1;
    localparam int unsigned ArmW   = $clog2(ArmCnt + 1);

    logic [STROBE_W-1:0] s;
    logic [STROBE_W-1:0] p;
    logic [ArmW-1:0]     arm_cnt;
    logic                armed;
    logic [STROBE_W-1:0] fall;
    logic [STROBE_W-1:0] pending;
    logic [STROBE_W-1:0] ack_mask;
    logic [STROBE_W-1:0] cand;
    logic                ack;
    logic                load;
    logic                ovr_set;
    logic [CODE_W-1:0]   cand_idx;
    logic                cand_any;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign s = y_n;
        end else begin : g_sync
            // Stage 0 in the low slice; the oldest stage sits at the top.
            logic [SyncW-1:0] sync_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_q <= {SYNC_STAGES{SYNC_RESET}};
                end else begin
                    sync_q <= (sync_q << STROBE_W) | SyncW'(y_n);
                end
            end

            assign s = sync_q[SyncW-1 -: STROBE_W];
        end
    endgenerate

    // Edges stay masked until s and p both hold real samples, so a line held low
    // through reset release is not mistaken for a fresh falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p       <= SYNC_RESET;
            arm_cnt <= '0;
        end else begin
            p <= s;
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    assign armed = (arm_cnt == ArmW'(ArmCnt));

    always_comb begin
        fall     = armed ? (p & ~s) : '0;
        ack      = valid & ready;
        ack_mask = ack ? (STROBE_W'(1) << code) : '0;
        cand     = pending & ~ack_mask;
        load     = ~valid | ack;
        ovr_set  = |(fall & cand);
    end

    priority_enc_16 u_prio (
        .vec (cand),
        .idx (cand_idx),
        .any (cand_any)
    );

    // Same-cycle edges join pending but are not in cand, so they present a cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            valid   <= 1'b0;
            code    <= '0;
            overrun <= 1'b0;
        end else begin
            pending <= cand | fall;
            overrun <= ovr_set | (overrun & ~overrun_clr);
            if (load) begin
                valid <= cand_any;
                code  <= cand_idx;
            end
        end
    end

endmodule

// File: tb/tb_strobe_encoder_16.sv
// Bench for strobe_encoder_16: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an event-level reference model.
module tb_strobe_encoder_16;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] y_n = '1;
    logic        ready = 1'b1;
    logic        overrun_clr = 1'b0;
    logic [3:0]  code;
    logic        valid;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    strobe_encoder_16 #(.SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .reset       (reset),
        .y_n         (y_n),
        .code        (code),
        .valid       (valid),
        .ready       (ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Reference model: a set of pending event indices, the presented event and a sticky
    // loss flag, fed by a history of sampled y_n words.
    logic [15:0] seen[$];
    bit          m_pend[16];
    bit          m_valid;
    int          m_code;
    bit          m_ovr;
    int          edges_seen;
    logic [15:0] m_s;
    logic [15:0] m_p;
    int          acked;
    bit          kept[16];
    bit          fell[16];
    bit          set_ovr;

    task automatic model_reset();
        seen.delete();
        for (int i = 0; i <= SYNC; i++) seen.push_back(16'hFFFF);
        for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
        m_valid    = 1'b0;
        m_code     = 0;
        m_ovr      = 1'b0;
        edges_seen = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            // seen[0] is the word sampled now, seen[k] the word sampled k edges ago.
            seen.push_front(y_n);
            m_s = seen[SYNC];
            m_p = seen[SYNC + 1];
            void'(seen.pop_back());
            acked   = (m_valid && ready) ? m_code : -1;
            set_ovr = 1'b0;
            for (int i = 0; i < 16; i++) begin
                kept[i] = m_pend[i] && (i != acked);
                fell[i] = (edges_seen > SYNC) && m_p[i] && !m_s[i];
                if (fell[i] && kept[i]) set_ovr = 1'b1;
            end
            if (!m_valid || acked >= 0) begin
                m_valid = 1'b0;
                m_code  = 0;
                for (int i = 15; i >= 0; i--) begin
                    if (kept[i]) begin
                        m_valid = 1'b1;
                        m_code  = i;
                    end
                end
            end
            for (int i = 0; i < 16; i++) m_pend[i] = kept[i] || fell[i];
            m_ovr = set_ovr || (m_ovr && !overrun_clr);
            edges_seen++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_valid", {31'b0, valid}, {31'b0, m_valid});
            chk("model_code", {28'b0, code}, m_code);
            chk("model_overrun", {31'b0, overrun}, {31'b0, m_ovr});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle();
        y_n         = '1;
        ready       = 1'b1;
        overrun_clr = 1'b0;
        step(6);
        chk("idle_valid", {31'b0, valid}, 32'd0);
    endtask

    initial begin
        step(2);
        chk("reset_valid", {31'b0, valid}, 32'd0);
        chk("reset_code", {28'b0, code}, 32'd0);
        chk("reset_overrun", {31'b0, overrun}, 32'd0);
        reset = 1'b0;
        idle();

        // Single strobe: visible at edge 4 for exactly one cycle.
        y_n[5] = 1'b0;
        step(3);
        chk("t1_not_early", {31'b0, valid}, 32'd0);
        y_n[5] = 1'b1;
        step(1);
        chk("t1_valid", {31'b0, valid}, 32'd1);
        chk("t1_code", {28'b0, code}, 32'd5);
        step(1);
        chk("t1_valid_drop", {31'b0, valid}, 32'd0);
        chk("t1_overrun", {31'b0, overrun}, 32'd0);
        idle();

        // Simultaneous strobes drain lowest first, back to back.
        ready = 1'b0;
        y_n[3] = 1'b0; y_n[9] = 1'b0; y_n[14] = 1'b0;
        step(4);
        chk("t2_first", {28'b0, code}, 32'd3);
        y_n = '1;
        step(3);
        chk("t2_held_valid", {31'b0, valid}, 32'd1);
        chk("t2_held_code", {28'b0, code}, 32'd3);
        ready = 1'b1;
        step(1);
        chk("t2_second", {28'b0, code}, 32'd9);
        step(1);
        chk("t2_third", {28'b0, code}, 32'd14);
        step(1);
        chk("t2_empty", {31'b0, valid}, 32'd0);
        idle();

        // Hold rule: a lower index arriving later does not displace the presented code.
        ready = 1'b0;
        y_n[7] = 1'b0;
        step(4);
        chk("t3_code7", {28'b0, code}, 32'd7);
        y_n[1] = 1'b0;
        step(5);
        chk("t3_hold", {28'b0, code}, 32'd7);
        ready = 1'b1;
        step(1);
        chk("t3_next", {28'b0, code}, 32'd1);
        step(1);
        chk("t3_empty", {31'b0, valid}, 32'd0);
        idle();

        // Overrun: second edge on an unserviced line is lost and flagged.
        ready = 1'b0;
        y_n[2] = 1'b0; step(2);
        y_n[2] = 1'b1; step(2);
        y_n[2] = 1'b0; step(5);
        chk("t4_overrun_set", {31'b0, overrun}, 32'd1);
        chk("t4_code", {28'b0, code}, 32'd2);
        ready = 1'b1;
        step(1);
        chk("t4_single", {31'b0, valid}, 32'd0);
        chk("t4_sticky", {31'b0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        chk("t4_cleared", {31'b0, overrun}, 32'd0);
        idle();

        // Edge on the presented line during its own ack: one bubble, then again.
        ready = 1'b0;
        y_n[6] = 1'b0; step(4);
        chk("t5_code6", {28'b0, code}, 32'd6);
        y_n[6] = 1'b1; step(3);
        y_n[6] = 1'b0; step(2);
        ready = 1'b1;
        step(1);
        chk("t5_bubble", {31'b0, valid}, 32'd0);
        step(1);
        chk("t5_again_valid", {31'b0, valid}, 32'd1);
        chk("t5_again_code", {28'b0, code}, 32'd6);
        step(1);
        chk("t5_done", {31'b0, valid}, 32'd0);
        chk("t5_no_overrun", {31'b0, overrun}, 32'd0);
        idle();

        // Reset mid-operation clears everything; held-low lines need a fresh fall.
        ready = 1'b0;
        y_n[0] = 1'b0; y_n[4] = 1'b0; y_n[8] = 1'b0;
        step(5);
        y_n[4] = 1'b1; step(2);
        y_n[4] = 1'b0; step(4);
        chk("t6_pre_overrun", {31'b0, overrun}, 32'd1);
        chk("t6_pre_code", {28'b0, code}, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_valid", {31'b0, valid}, 32'd0);
        chk("t6_async_code", {28'b0, code}, 32'd0);
        chk("t6_async_overrun", {31'b0, overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(8);
        chk("t6_no_event", {31'b0, valid}, 32'd0);
        y_n = '1; step(4);
        y_n[0] = 1'b0; y_n[4] = 1'b0; y_n[8] = 1'b0;
        step(4);
        chk("t6_retrigger_valid", {31'b0, valid}, 32'd1);
        chk("t6_retrigger_code", {28'b0, code}, 32'd0);
        idle();

        // Randomized traffic, occasional clears and resets; the model checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 9) == 0) y_n[b] = ~y_n[b];
            end
            ready       = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
            reset       = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
